// File: rtl/gram_pkg.sv
// Shared constants and types for the gram write-port controller.
package gram_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned DEPTH  = 2400;

  localparam logic [DATA_W-1:0] SPACE_CHAR = 7'h20;

  typedef enum logic {IDLE, FILL} gram_state_e;

endpackage

// File: rtl/gram_write_ctrl_rr_arb2.sv
// Two-requester arbiter: round-robin when GRAM_WR_RR_EN is defined, fixed priority
// (requester 0 first) otherwise.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef GRAM_WR_RR_EN
  logic prio_q;  // 1: requester 1 is favoured on the next conflict

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      prio_q <= grant[0];
    end
  end
`else
  logic unused_sigs;

  assign grant       = {valid[1] & ~valid[0], valid[0]};
  assign unused_sigs = ^{clk, rst_n, advance};
`endif

endmodule

// File: rtl/gram_write_ctrl.sv
// Write-port sequencer for the text-mode character RAM: arbitrates two requesters and runs a
// full-screen fill engine. Arbitration policy selected by GRAM_WR_RR_EN (see rr_arb2).
module gram_write_ctrl
  import gram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] gram_wraddress,
  output logic [DATA_W-1:0] gram_data,
  output logic              gram_wren
);

  gram_state_e       state_q;
  logic [ADDR_W-1:0] fill_cnt_q;
  logic [DATA_W-1:0] fill_char_q;
  logic [1:0]        valid_idle;
  logic [1:0]        grant;
  logic              xfer;
  logic              addr_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Requesters are only visible to the arbiter while the fill engine is parked.
  assign valid_idle = (state_q == IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid_idle),
    .advance (xfer),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign addr_ok    = sel_addr < ADDR_W'(DEPTH);
  assign fill_busy  = (state_q == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fill_cnt_q     <= '0;
      fill_char_q    <= '0;
      fill_done      <= 1'b0;
      addr_err       <= 1'b0;
      gram_wraddress <= '0;
      gram_data      <= '0;
      gram_wren      <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          gram_wren <= xfer & addr_ok;
          if (xfer && addr_ok) begin
            gram_wraddress <= sel_addr;
            gram_data      <= sel_data;
          end
          // Out-of-range transfers are still handshaked so the source never stalls.
          if (xfer && !addr_ok) addr_err <= 1'b1;
          if (fill_start) begin
            fill_char_q <= fill_data;
            fill_cnt_q  <= '0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          gram_wren      <= 1'b1;
          gram_wraddress <= fill_cnt_q;
          gram_data      <= fill_char_q;
          if (fill_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q   <= IDLE;
            fill_done <= 1'b1;
          end else begin
            fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gram_write_ctrl.sv
// Directed bench for gram_write_ctrl: arbitration, range errors, fill engine, mid-fill reset.
module tb_gram_write_ctrl;
  import gram_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready;
  logic              fill_start = 1'b0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              fill_busy, fill_done, addr_err;
  logic [ADDR_W-1:0] gram_wraddress;
  logic [DATA_W-1:0] gram_data;
  logic              gram_wren;

  int checks = 0;
  int errors = 0;

  gram_write_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .fill_start     (fill_start),
    .fill_data      (fill_data),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .addr_err       (addr_err),
    .gram_wraddress (gram_wraddress),
    .gram_data      (gram_data),
    .gram_wren      (gram_wren)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wren"}, 32'(gram_wren), 0);
    check({tag, "_waddr"}, 32'(gram_wraddress), 0);
    check({tag, "_wdata"}, 32'(gram_data), 0);
    check({tag, "_rdy0"}, 32'(req0_ready), 0);
    check({tag, "_rdy1"}, 32'(req1_ready), 0);
    check({tag, "_busy"}, 32'(fill_busy), 0);
    check({tag, "_done"}, 32'(fill_done), 0);
    check({tag, "_aerr"}, 32'(addr_err), 0);
  endtask

  initial begin
    int writes, busy_cyc, rdy_hi, order_err, done_cnt, done_cyc, last_addr, stray;
    bit exp0, hit;

    // Reset values, requesters idle.
    tick(); tick(); tick();
    check_reset_vals("rst");

    // Both requesters valid across reset release: req0 first, then req1.
    req0_valid = 1'b1; req0_addr = 12'd5; req0_data = 7'h41;
    req1_valid = 1'b1; req1_addr = 12'd6; req1_data = 7'h42;
    rst_n = 1'b1;
    #1;
    check("first_rdy0", 32'(req0_ready), 1);
    check("first_rdy1", 32'(req1_ready), 0);
    tick();
    check("first_wren", 32'(gram_wren), 1);
    check("first_waddr", 32'(gram_wraddress), 5);
    check("first_wdata", 32'(gram_data), 32'h41);
    req0_valid = 1'b0;
    #1;
    check("second_rdy1", 32'(req1_ready), 1);
    tick();
    check("second_wren", 32'(gram_wren), 1);
    check("second_waddr", 32'(gram_wraddress), 6);
    check("second_wdata", 32'(gram_data), 32'h42);
    req1_valid = 1'b0;
    tick();
    check("idle_wren", 32'(gram_wren), 0);

    // Eight cycles of continuous contention.
    req0_valid = 1'b1; req0_addr = 12'd100; req0_data = 7'h10;
    req1_valid = 1'b1; req1_addr = 12'd200; req1_data = 7'h20;
    for (int i = 0; i < 8; i++) begin
`ifdef GRAM_WR_RR_EN
      exp0 = (i % 2) == 0;
`else
      exp0 = 1'b1;
`endif
      #1;
      check($sformatf("arb%0d_rdy0", i), 32'(req0_ready), 32'(exp0));
      check($sformatf("arb%0d_rdy1", i), 32'(req1_ready), 32'(!exp0));
      tick();
      check($sformatf("arb%0d_wren", i), 32'(gram_wren), 1);
      check($sformatf("arb%0d_waddr", i), 32'(gram_wraddress), exp0 ? 100 : 200);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Out-of-range write is handshaked but dropped; addr_err is sticky.
    req0_valid = 1'b1; req0_addr = 12'd2400; req0_data = 7'h41;
    #1;
    check("oor_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("oor_wren", 32'(gram_wren), 0);
    check("oor_aerr", 32'(addr_err), 1);
    req1_valid = 1'b1; req1_addr = 12'd2399; req1_data = 7'h7f;
    #1;
    check("last_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    check("last_wren", 32'(gram_wren), 1);
    check("last_waddr", 32'(gram_wraddress), 2399);
    tick(); tick();
    check("aerr_sticky", 32'(addr_err), 1);

    // Fill started alongside a req1 handshake; second fill_start mid-fill ignored.
    req1_valid = 1'b1; req1_addr = 12'd10; req1_data = 7'h55;
    fill_start = 1'b1; fill_data = 7'h20;
    #1;
    check("fillreq_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0; fill_start = 1'b0;
    check("fillreq_wren", 32'(gram_wren), 1);
    check("fillreq_waddr", 32'(gram_wraddress), 10);
    check("fillreq_wdata", 32'(gram_data), 32'h55);
    check("fill_busy_n1", 32'(fill_busy), 1);
    req0_valid = 1'b1; req0_addr = 12'd300; req0_data = 7'h11;
    writes = 0; busy_cyc = 1; rdy_hi = 0; order_err = 0;
    done_cnt = 0; done_cyc = 0; last_addr = -1;
    for (int c = 2; c < 3000 && done_cnt == 0; c++) begin
      tick();
      if (fill_busy) busy_cyc++;
      if (fill_busy && (req0_ready || req1_ready)) rdy_hi++;
      if (gram_wren) begin
        if (gram_wraddress != 12'(writes) || gram_data != 7'h20) order_err++;
        last_addr = int'(gram_wraddress);
        writes++;
      end
      if (fill_done) begin
        done_cnt++;
        done_cyc = c;
      end
      fill_start = (c == 500);
      fill_data  = (c == 500) ? 7'h33 : 7'h20;
    end
    check("fill_writes", 32'(writes), 2400);
    check("fill_busy_cycles", 32'(busy_cyc), 2400);
    check("fill_ready_high", 32'(rdy_hi), 0);
    check("fill_order", 32'(order_err), 0);
    check("fill_last_addr", 32'(last_addr), 2399);
    check("fill_done_count", 32'(done_cnt), 1);
    check("fill_done_cycle", 32'(done_cyc), 2401);
    check("fill_end_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("fill_done_pulse", 32'(fill_done), 0);
    check("post_fill_wren", 32'(gram_wren), 1);
    check("post_fill_waddr", 32'(gram_wraddress), 300);

    // Reset asserted at fill write 1000.
    tick();
    fill_start = 1'b1; fill_data = 7'h2a;
    tick();
    fill_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 1200 && !hit; c++) begin
      tick();
      if (gram_wren && gram_wraddress == 12'd1000) hit = 1'b1;
    end
    check("midrst_reached", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      stray += int'(fill_done) + int'(fill_busy) + int'(gram_wren);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      stray += int'(fill_done) + int'(fill_busy) + int'(gram_wren);
    end
    check("midrst_quiet", 32'(stray), 0);
    req0_valid = 1'b1; req0_addr = 12'd7; req0_data = 7'h61;
    #1;
    check("after_rst_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("after_rst_wren", 32'(gram_wren), 1);
    check("after_rst_waddr", 32'(gram_wraddress), 7);
    check("after_rst_wdata", 32'(gram_data), 32'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
